// File: rtl/weight_read_sequencer_if.sv
// Handshake and memory bundle for weight_read_sequencer.
// master = sample/memory side (bench), slave = sequencer.
interface weight_read_sequencer_if #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    in_valid;
    logic                    in_ready;
    logic [dataWidth-1:0]    in_data;
    logic                    mem_ren;
    logic [addressWidth:0]   mem_raddr;
    logic [dataWidth-1:0]    mem_wout;
    logic                    pair_valid;
    logic [dataWidth-1:0]    pair_data;
    logic [dataWidth-1:0]    pair_weight;
    logic                    pair_last;

    modport master (
        output start, in_valid, in_data, mem_wout,
        input  busy, done, in_ready, mem_ren, mem_raddr,
        input  pair_valid, pair_data, pair_weight, pair_last
    );

    modport slave (
        input  start, in_valid, in_data, mem_wout,
        output busy, done, in_ready, mem_ren, mem_raddr,
        output pair_valid, pair_data, pair_weight, pair_last
    );
endinterface

// File: rtl/weight_read_sequencer.sv
// Weight BRAM read sequencer: pairs each input sample with its weight.
// Optional WEIGHT_SEQ_STALL_CNT_EN adds a 16-bit RUN-stall counter.
module weight_read_sequencer #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef WEIGHT_SEQ_STALL_CNT_EN
    output logic [15:0]              stall_cnt,
`endif
    weight_read_sequencer_if.slave   bus
);
    localparam logic [addressWidth-1:0] LP_LAST =
        addressWidth'(numWeight - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t                  r_state;
    logic [addressWidth-1:0] r_addr;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_pv;
    logic                    r_last;
    logic [dataWidth-1:0]    r_data;
    logic                    w_run;
    logic                    w_accept;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = w_run & bus.in_valid;

    assign bus.in_ready    = w_run;
    assign bus.mem_ren     = w_accept;
    assign bus.mem_raddr   = {1'b0, r_addr};
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pair_valid  = r_pv;
    assign bus.pair_last   = r_last;
    assign bus.pair_data   = r_data;
    assign bus.pair_weight = bus.mem_wout;

    // Sequencer FSM: address counter, sample delay and pair flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pv    <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_pv   <= w_accept;
            r_last <= 1'b0;
            r_done <= 1'b0;
            if (w_accept) begin
                r_data <= bus.in_data;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_addr == LP_LAST) begin
                            r_addr  <= '0;
                            r_last  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FLUSH;
                        end else begin
                            r_addr <= r_addr + addressWidth'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0] r_stall;

    assign stall_cnt = r_stall;

    // Count RUN cycles without a sample; saturating, cleared on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_stall <= '0;
        end else if (w_run && !bus.in_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_weight_read_sequencer.sv
// Bench for weight_read_sequencer: numWeight=4 with a per-cycle model,
// plus a numWeight=1 instance checked with literal expectations.
module tb_weight_read_sequencer;
    localparam int NW = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always #5 clk = ~clk;

    weight_read_sequencer_if #(.addressWidth(AW), .dataWidth(DW)) b ();
    weight_read_sequencer_if #(.addressWidth(AW), .dataWidth(DW)) b1 ();

`ifdef WEIGHT_SEQ_STALL_CNT_EN
    logic [15:0] stall0;
    logic [15:0] stall1;
`endif

    weight_read_sequencer #(
        .numWeight(NW), .addressWidth(AW), .dataWidth(DW)
    ) u0 (
        .clk(clk),
        .rst(rst),
`ifdef WEIGHT_SEQ_STALL_CNT_EN
        .stall_cnt(stall0),
`endif
        .bus(b.slave)
    );

    weight_read_sequencer #(
        .numWeight(1), .addressWidth(AW), .dataWidth(DW)
    ) u1 (
        .clk(clk),
        .rst(rst),
`ifdef WEIGHT_SEQ_STALL_CNT_EN
        .stall_cnt(stall1),
`endif
        .bus(b1.slave)
    );

    // Weight memories with 1-cycle read latency, mem[i] = 0x100 + i.
    always @(posedge clk) begin
        if (rst) begin
            b.mem_wout  <= 16'h0;
            b1.mem_wout <= 16'h0;
        end else begin
            if (b.mem_ren)  b.mem_wout  <= 16'(16'h0100 + b.mem_raddr);
            if (b1.mem_ren) b1.mem_wout <= 16'(16'h0100 + b1.mem_raddr);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model: a sequence is "running" until NW samples are taken.
    bit          m_ok = 0;
    bit          m_run, m_busy, m_pv, m_last, m_done, m_acc;
    int          m_cnt;
    logic [15:0] m_pd, m_pw, m_stall;

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1; m_run = 0; m_busy = 0; m_cnt = 0;
            m_pv = 0; m_last = 0; m_done = 0; m_stall = 0;
        end else begin
            m_acc  = m_run && (b.in_valid === 1'b1);
            m_pv   = m_acc;
            m_last = 0;
            m_done = 0;
            if (m_acc) begin
                m_pd = b.in_data;
                m_pw = 16'(256 + m_cnt);
                m_cnt++;
                if (m_cnt == NW) begin
                    m_last = 1; m_done = 1; m_run = 0; m_cnt = 0;
                end
            end else if (m_run && m_stall != 16'hFFFF) begin
                m_stall++;
            end
            if (!m_busy && b.start) begin
                m_run = 1; m_cnt = 0; m_stall = 0;
            end
            m_busy = m_run || m_last;
        end
    end

    // Per-cycle comparison of instance u0 against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy", b.busy, m_busy);
            chk("in_ready", b.in_ready, m_run);
            chk("mem_ren", b.mem_ren, m_run && b.in_valid);
            chk("mem_raddr", b.mem_raddr, m_run ? m_cnt : 0);
            chk("pair_valid", b.pair_valid, m_pv);
            chk("pair_last", b.pair_last, m_last);
            chk("done", b.done, m_done);
            if (m_pv) begin
                chk("pair_data", b.pair_data, m_pd);
                chk("pair_weight", b.pair_weight, m_pw);
            end
`ifdef WEIGHT_SEQ_STALL_CNT_EN
            chk("stall_cnt", stall0, m_stall);
`endif
            if (b.done === 1'b1) n_done++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic feed(input logic v, input logic [15:0] d);
        b.in_valid = v;
        b.in_data  = d;
        step();
    endtask

    initial begin
        rst = 1'b1;
        b.start = 0;  b.in_valid = 0;  b.in_data = 0;
        b1.start = 0; b1.in_valid = 0; b1.in_data = 0;
        step(); step();
        rst = 1'b0;
        neg();
        chk("rst_busy", b.busy, 0);
        chk("rst_ready", b.in_ready, 0);
        chk("rst_pv", b.pair_valid, 0);
        step(); step();

        // back-to-back stream
        b.start = 1; step(); b.start = 0;
        b.in_valid = 1; b.in_data = 10;
        neg();
        chk("b2b_ren0", b.mem_ren, 1);
        chk("b2b_addr0", b.mem_raddr, 0);
        step(); b.in_data = 11;
        neg();
        chk("b2b_p0_data", b.pair_data, 10);
        chk("b2b_p0_w", b.pair_weight, 16'h0100);
        chk("b2b_addr1", b.mem_raddr, 1);
        step(); b.in_data = 12;
        step(); b.in_data = 13;
        step(); b.in_valid = 0;
        neg();
        chk("b2b_p3_data", b.pair_data, 13);
        chk("b2b_p3_w", b.pair_weight, 16'h0103);
        chk("b2b_last", b.pair_last, 1);
        chk("b2b_done", b.done, 1);
        step();
        neg();
        chk("b2b_idle", b.busy, 0);
        step();

        // gapped stream 1,0,0,1,1,0,1
        b.start = 1; step(); b.start = 0;
        feed(1, 40); feed(0, 0); feed(0, 0); feed(1, 41);
        feed(1, 42); feed(0, 0); feed(1, 43);
        b.in_valid = 0;
        neg();
        chk("gap_done", b.done, 1);
        chk("gap_w", b.pair_weight, 16'h0103);
`ifdef WEIGHT_SEQ_STALL_CNT_EN
        chk("gap_stall", stall0, 3);
`endif
        step(); step();

        // start ignored while busy, and on the FLUSH cycle
        n_done = 0;
        b.start = 1; step(); b.start = 0;
        feed(1, 20);
        b.start = 1; feed(1, 21); b.start = 0;
        feed(1, 22); feed(1, 23);
        b.in_valid = 0; b.start = 1;
        neg();
        chk("ign_w", b.pair_weight, 16'h0103);
        step(); b.start = 0;
        neg();
        chk("ign_flush_start", b.busy, 0);
        step(); step();
        chk("ign_one_done", n_done, 1);

        // reset mid-sequence
        n_done = 0;
        b.start = 1; step(); b.start = 0;
        feed(1, 50); feed(1, 51);
        b.in_valid = 0; rst = 1; step(); rst = 0;
        neg();
        chk("mid_busy", b.busy, 0);
        chk("mid_pv", b.pair_valid, 0);
        step(); step();
        chk("mid_no_done", n_done, 0);
        b.start = 1; step(); b.start = 0;
        b.in_valid = 1; b.in_data = 60;
        neg();
        chk("mid_addr0", b.mem_raddr, 0);
        step(); b.in_data = 61;
        neg();
        chk("mid_w0", b.pair_weight, 16'h0100);
        step(); b.in_data = 62;
        step(); b.in_data = 63;
        step(); b.in_valid = 0;
        step(); step();

        // numWeight=1 instance
        b1.start = 1; step(); b1.start = 0;
        b1.in_valid = 1; b1.in_data = 7;
        neg();
        chk("n1_ready", b1.in_ready, 1);
        chk("n1_ren", b1.mem_ren, 1);
        chk("n1_addr", b1.mem_raddr, 0);
        step(); b1.in_valid = 0;
        neg();
        chk("n1_pv", b1.pair_valid, 1);
        chk("n1_data", b1.pair_data, 7);
        chk("n1_w", b1.pair_weight, 16'h0100);
        chk("n1_last", b1.pair_last, 1);
        chk("n1_done", b1.done, 1);
        step();
        neg();
        chk("n1_idle", b1.busy, 0);
        chk("n1_pv_off", b1.pair_valid, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/weight_read_sequencer.md
Name: weight_read_sequencer

Overview:
- Controller for one neuron's weight memory in layer `layerNo`.
- Generates the read-enable and read-address sequence for the weight BRAM and hides its 1-cycle read latency.
- Delays each accepted input sample so it arrives at the neuron MAC together with its matching weight.
- One sequence per `start`: `numWeight` input/weight pairs, then a `done` pulse.

Parameters:
- numWeight, 784, weights per neuron = input samples per sequence (legal range 1 .. 2**addressWidth)
- addressWidth, 10, weight memory address width; the memory address port is addressWidth+1 bits
- dataWidth, 16, width of input samples and weights

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a sequence; honoured only in IDLE
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse, coincident with the last pair
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample (high only in RUN)
- in_data  in  dataWidth  input sample
- mem_ren  out  1  weight memory read enable
- mem_raddr  out  addressWidth+1  weight memory read address
- mem_wout  in  dataWidth  weight memory read data (valid 1 cycle after mem_ren)
- pair_valid  out  1  pair_data/pair_weight valid this cycle
- pair_data  out  dataWidth  delayed input sample
- pair_weight  out  dataWidth  weight for pair_data (driven directly from mem_wout)
- pair_last  out  1  marks the final pair of a sequence

Behaviour:
- Reset (sync, rst=1):
  - state=IDLE, addr=0.
  - busy, done, pair_valid, pair_last, data register all 0.
  - rst has priority over every other input, including mid-sequence; the partial sequence is abandoned with no done pulse.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - in_ready=0, mem_ren=0, mem_raddr=0.
  - start=1 -> RUN, addr<=0.
- RUN:
  - in_ready=1; accept = in_valid & in_ready.
  - mem_ren = accept (combinational); mem_raddr = addr (registered counter, zero-extended to addressWidth+1).
  - On accept: data register <= in_data; pair_valid next cycle <= 1.
  - On accept with addr < numWeight-1: addr <= addr+1.
  - On accept with addr == numWeight-1: addr <= 0, pair_last next cycle <= 1, state -> FLUSH.
  - in_valid=0: no read, addr holds, pair_valid next cycle = 0. Gaps of any length are legal.
- FLUSH (exactly 1 cycle):
  - in_ready=0, mem_ren=0.
  - Outputs the final pair: pair_valid=1, pair_last=1, done=1.
  - -> IDLE.
- Latency: accepted sample at cycle N -> pair_valid at cycle N+1, with pair_weight = mem[addr at N].
- Weight alignment: pair_weight passes mem_wout straight through. mem_wout holds its value while mem_ren=0, which is safe because pair_valid is 0 on those cycles.
- No backpressure on the pair side; the MAC must consume one pair per cycle.
- start outside IDLE (RUN or FLUSH) is ignored; no queueing.
- start in the same cycle as done/FLUSH is ignored; a new start is honoured from the next cycle (in IDLE).
- numWeight=1: first accept goes straight to FLUSH; that single pair carries pair_last and done.
- Address wraps to 0 only at end of sequence; it never exceeds numWeight-1.

Optional Feature:
- Macro: WEIGHT_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Counts RUN cycles with in_valid=0.
  - Cleared by rst and on each honoured start.
  - Saturates at 16'hFFFF and holds its value in IDLE.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan (numWeight=4, memory preloaded with mem[i]=16'h0100+i):
- Reset then idle: rst=1 for 2 cycles, start=0 -> busy=0, in_ready=0, mem_ren=0, pair_valid=0, done=0 throughout.
- Back-to-back stream:
  - Stimulus: start; then in_data 10,11,12,13 on 4 consecutive cycles.
  - mem_raddr 0,1,2,3 with mem_ren=1 on each accept cycle.
  - Pairs (10,0x100),(11,0x101),(12,0x102),(13,0x103), each 1 cycle after its accept.
  - pair_last and done high only on the 4th pair; busy drops the following cycle.
- Gapped stream:
  - Stimulus: in_valid pattern 1,0,0,1,1,0,1 -> 4 pairs, weights still 0x100..0x103 in order.
  - mem_ren=0 on gap cycles.
  - With WEIGHT_SEQ_STALL_CNT_EN defined, stall_cnt=3 at done.
- Start ignored while busy: pulse start mid-RUN -> addr not reset, pairs and weights continue in order, exactly one done pulse.
- Reset mid-sequence: after 2 accepts assert rst -> next cycle IDLE, no done pulse. A new start then reads from mem_raddr=0 (weight 0x100).
- numWeight=1 variant: start, one sample 7 -> single pair (7,0x100) with pair_last=1 and done=1, then IDLE.
